// File: rtl/relobi_a_arbiter.sv
// Round-robin arbiter from N managers onto one subordinate, with an in-order ID FIFO to route responses.
// Optional macro RELOBI_A_ARB_ECC_CHECK_EN re-encodes the forwarded field and flags check-bit mismatches.
module relobi_a_arbiter #(
    parameter int unsigned NumMgr        = 4,
    parameter int unsigned OtherWidth    = 41,
    parameter int unsigned OtherEccWidth = 7,
    parameter int unsigned MaxTrans      = 4
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic [NumMgr-1:0]                 mgr_req_i,
    output logic [NumMgr-1:0]                 mgr_gnt_o,
    input  logic [NumMgr*OtherWidth-1:0]      mgr_other_i,
    input  logic [NumMgr*OtherEccWidth-1:0]   mgr_other_ecc_i,
    output logic                              sbr_req_o,
    input  logic                              sbr_gnt_i,
    output logic [OtherWidth-1:0]             sbr_other_o,
    output logic [OtherEccWidth-1:0]          sbr_other_ecc_o,
    input  logic                              sbr_rvalid_i,
    output logic [NumMgr-1:0]                 mgr_rvalid_o,
    output logic                              fault_o
);

    localparam int unsigned IdxW = $clog2(NumMgr);
    localparam int unsigned PtrW = $clog2(MaxTrans);
    localparam int unsigned CntW = $clog2(MaxTrans) + 1;

    logic [IdxW-1:0] r_prio;
    logic [IdxW-1:0] r_sel;
    logic            r_lock;
    logic [IdxW-1:0] r_fifo [MaxTrans];
    logic [PtrW-1:0] r_wptr;
    logic [PtrW-1:0] r_rptr;
    logic [CntW-1:0] r_cnt;

    logic [IdxW-1:0] w_rr_sel;
    logic            w_rr_found;
    logic [IdxW-1:0] w_sel;
    logic            w_hold;
    logic            w_drop;
    logic            w_full;
    logic            w_empty;
    logic            w_pop;
    logic            w_stray;
    logic            w_hs;
    logic            w_ecc_err;

    function automatic logic [IdxW-1:0] wrap_add(input logic [IdxW-1:0] base, input int unsigned off);
        int unsigned s;
        s = 32'(base) + off;
        if (s >= NumMgr) s = s - NumMgr;
        return IdxW'(s);
    endfunction

    // First requester at or after the priority pointer
    always_comb begin
        w_rr_sel   = r_prio;
        w_rr_found = 1'b0;
        for (int unsigned i = 0; i < NumMgr; i++) begin
            if (!w_rr_found && mgr_req_i[wrap_add(r_prio, i)]) begin
                w_rr_sel   = wrap_add(r_prio, i);
                w_rr_found = 1'b1;
            end
        end
    end

    assign w_hold  = r_lock & mgr_req_i[r_sel];
    assign w_drop  = r_lock & ~mgr_req_i[r_sel];
    assign w_sel   = w_hold ? r_sel : w_rr_sel;

    assign w_full  = (r_cnt == CntW'(MaxTrans));
    assign w_empty = (r_cnt == '0);
    assign w_pop   = rst_ni & sbr_rvalid_i & ~w_empty;
    assign w_stray = sbr_rvalid_i & w_empty;

    // A pop in the same cycle frees the slot, so a full FIFO may still take a handshake
    assign sbr_req_o = rst_ni & (|mgr_req_i) & (~w_full | sbr_rvalid_i);
    assign w_hs      = sbr_req_o & sbr_gnt_i;

    always_comb begin
        mgr_gnt_o       = '0;
        mgr_rvalid_o    = '0;
        sbr_other_o     = '0;
        sbr_other_ecc_o = '0;
        for (int unsigned i = 0; i < NumMgr; i++) begin
            if (w_sel == IdxW'(i)) begin
                mgr_gnt_o[i]    = w_hs;
                sbr_other_o     = mgr_other_i[i*OtherWidth +: OtherWidth];
                sbr_other_ecc_o = mgr_other_ecc_i[i*OtherEccWidth +: OtherEccWidth];
            end
            if (r_fifo[r_rptr] == IdxW'(i)) mgr_rvalid_o[i] = w_pop;
        end
    end

`ifdef RELOBI_A_ARB_ECC_CHECK_EN
    localparam int unsigned DatIdxW = (OtherWidth > 1) ? $clog2(OtherWidth) : 1;

    // Hsiao code: odd-weight columns (weight >= 3), lowest weight first, ascending value
    function automatic logic [OtherEccWidth-1:0] hsiao_enc(input logic [OtherWidth-1:0] d);
        logic [OtherEccWidth-1:0] c;
        int unsigned              col;
        c   = '0;
        col = 0;
        for (int w = 3; w <= int'(OtherEccWidth); w += 2) begin
            for (int v = 1; v < (1 << OtherEccWidth); v++) begin
                if ($countones(OtherEccWidth'(v)) == w && col < OtherWidth) begin
                    if (d[DatIdxW'(col)]) c = c ^ OtherEccWidth'(v);
                    col = col + 1;
                end
            end
        end
        return c;
    endfunction

    assign w_ecc_err = sbr_req_o & (hsiao_enc(sbr_other_o) != sbr_other_ecc_o);
`else
    assign w_ecc_err = 1'b0;
`endif

    assign fault_o = rst_ni & (w_stray | w_drop | w_ecc_err);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_prio <= '0;
            r_sel  <= '0;
            r_lock <= 1'b0;
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
        end else begin
            r_lock <= sbr_req_o & ~sbr_gnt_i;
            r_sel  <= w_sel;
            if (w_hs) begin
                r_prio <= wrap_add(w_sel, 1);
                r_wptr <= r_wptr + PtrW'(1);
            end
            if (w_pop) r_rptr <= r_rptr + PtrW'(1);
            case ({w_hs, w_pop})
                2'b10:   r_cnt <= r_cnt + CntW'(1);
                2'b01:   r_cnt <= r_cnt - CntW'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    // ID storage needs no reset; the count and pointers qualify every read
    always_ff @(posedge clk_i) begin
        if (rst_ni && w_hs) r_fifo[r_wptr] <= w_sel;
    end

endmodule

// File: tb/tb_relobi_a_arbiter.sv
// Bench for relobi_a_arbiter: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a queue-based reference model.
module tb_relobi_a_arbiter;

    localparam int NM = 4;
    localparam int OW = 41;
    localparam int EW = 7;
    localparam int MT = 4;

    logic              clk_i = 1'b0;
    logic              rst_ni;
    logic [NM-1:0]     mgr_req;
    logic [NM-1:0]     mgr_gnt;
    logic [NM*OW-1:0]  mgr_other;
    logic [NM*EW-1:0]  mgr_other_ecc;
    logic              sbr_req;
    logic              sbr_gnt;
    logic [OW-1:0]     sbr_other;
    logic [EW-1:0]     sbr_other_ecc;
    logic              sbr_rvalid;
    logic [NM-1:0]     mgr_rvalid;
    logic              fault;

    logic [OW-1:0] other_a [NM];
    logic [EW-1:0] ecc_a   [NM];

    int total = 0;
    int bad   = 0;

    always #5 clk_i = ~clk_i;

    always_comb begin
        mgr_other     = '0;
        mgr_other_ecc = '0;
        for (int i = 0; i < NM; i++) begin
            mgr_other[i*OW +: OW]     = other_a[i];
            mgr_other_ecc[i*EW +: EW] = ecc_a[i];
        end
    end

    relobi_a_arbiter #(
        .NumMgr(NM), .OtherWidth(OW), .OtherEccWidth(EW), .MaxTrans(MT)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .mgr_req_i(mgr_req), .mgr_gnt_o(mgr_gnt),
        .mgr_other_i(mgr_other), .mgr_other_ecc_i(mgr_other_ecc),
        .sbr_req_o(sbr_req), .sbr_gnt_i(sbr_gnt),
        .sbr_other_o(sbr_other), .sbr_other_ecc_o(sbr_other_ecc),
        .sbr_rvalid_i(sbr_rvalid), .mgr_rvalid_o(mgr_rvalid),
        .fault_o(fault)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Odd-weight column table for the check-bit code
    int col_mask [OW];
    function automatic logic [EW-1:0] enc(input logic [OW-1:0] d);
        logic [EW-1:0] c;
        c = '0;
        for (int j = 0; j < OW; j++) if (d[j]) c = c ^ EW'(col_mask[j]);
        return c;
    endfunction

    // Reference model: queue of granted manager IDs, priority index, pending-request owner
    int m_q[$];
    int m_prio   = 0;
    bit m_locked = 0;
    int m_lock_idx = 0;
    int m_req_bits, m_sel, m_exp_gnt, m_exp_rv;
    bit m_exp_req, m_exp_fault, m_found, m_drop, m_stray, m_ecc_bad;

    always @(negedge clk_i) begin
        if (!rst_ni) begin
            chk("rst_gnt", 64'(mgr_gnt), 64'd0);
            chk("rst_req", 64'(sbr_req), 64'd0);
            chk("rst_rvalid", 64'(mgr_rvalid), 64'd0);
            chk("rst_fault", 64'(fault), 64'd0);
            m_q.delete();
            m_prio   = 0;
            m_locked = 0;
        end else begin
            m_req_bits = int'(mgr_req);
            m_exp_req  = (m_req_bits != 0) && ((m_q.size() < MT) || sbr_rvalid);
            m_drop     = m_locked && (((m_req_bits >> m_lock_idx) & 1) == 0);
            if (m_locked && !m_drop) begin
                m_sel = m_lock_idx;
            end else begin
                m_sel = m_prio;
                m_found = 0;
                for (int i = 0; i < NM; i++) begin
                    if (!m_found && (((m_req_bits >> ((m_prio + i) % NM)) & 1) == 1)) begin
                        m_sel   = (m_prio + i) % NM;
                        m_found = 1;
                    end
                end
            end
            m_exp_gnt = (m_exp_req && sbr_gnt) ? (1 << m_sel) : 0;
            m_stray   = sbr_rvalid && (m_q.size() == 0);
            m_exp_rv  = (sbr_rvalid && m_q.size() > 0) ? (1 << m_q[0]) : 0;
`ifdef RELOBI_A_ARB_ECC_CHECK_EN
            m_ecc_bad = m_exp_req && (enc(other_a[m_sel]) != ecc_a[m_sel]);
`else
            m_ecc_bad = 0;
`endif
            m_exp_fault = m_stray || m_drop || m_ecc_bad;

            chk("req", 64'(sbr_req), 64'(m_exp_req));
            chk("gnt", 64'(mgr_gnt), 64'(m_exp_gnt));
            chk("rvalid", 64'(mgr_rvalid), 64'(m_exp_rv));
            chk("fault", 64'(fault), 64'(m_exp_fault));
            if (m_exp_req) begin
                chk("other", 64'(sbr_other), 64'(other_a[m_sel]));
                chk("other_ecc", 64'(sbr_other_ecc), 64'(ecc_a[m_sel]));
            end

            if (sbr_rvalid && m_q.size() > 0) void'(m_q.pop_front());
            if (m_exp_req && sbr_gnt) begin
                m_q.push_back(m_sel);
                m_prio = (m_sel + 1) % NM;
            end
            m_locked   = m_exp_req && !sbr_gnt;
            m_lock_idx = m_sel;
        end
    end

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input logic [NM-1:0] r, input logic g, input logic rv);
        step();
        mgr_req    = r;
        sbr_gnt    = g;
        sbr_rvalid = rv;
        #2;
    endtask

    task automatic set_mgr(input int i, input logic [OW-1:0] d);
        other_a[i] = d;
`ifdef RELOBI_A_ARB_ECC_CHECK_EN
        ecc_a[i] = enc(d);
`else
        ecc_a[i] = EW'($urandom);
`endif
    endtask

    int n;
    logic [OW-1:0] tmp;

    initial begin
        n = 0;
        for (int w = 3; w <= EW; w += 2)
            for (int v = 1; v < (1 << EW); v++)
                if ($countones(v) == w && n < OW) begin
                    col_mask[n] = v;
                    n++;
                end
        for (int i = 0; i < NM; i++) set_mgr(i, OW'(64'h1_0000_0000 + 64'(i) * 64'h111));
        rst_ni = 1'b0; mgr_req = '1; sbr_gnt = 1'b1; sbr_rvalid = 1'b1;

        // Reset holds every output low even with requests and responses present
        drive(4'hF, 1'b1, 1'b1);
        chk("lit_rst_req", 64'(sbr_req), 64'd0);
        drive(4'hF, 1'b1, 1'b1);
        chk("lit_rst_fault", 64'(fault), 64'd0);
        step(); rst_ni = 1'b1;

        // Continuous requests: 0,1,2,3 then full, then push+pop keeps count at 4
        mgr_req = 4'hF; sbr_gnt = 1'b1; sbr_rvalid = 1'b0; #2;
        chk("lit_rr0", 64'(mgr_gnt), 64'h1);
        chk("lit_rr0_other", 64'(sbr_other), 64'h1_0000_0000);
        drive(4'hF, 1'b1, 1'b0); chk("lit_rr1", 64'(mgr_gnt), 64'h2);
        drive(4'hF, 1'b1, 1'b0); chk("lit_rr2", 64'(mgr_gnt), 64'h4);
        drive(4'hF, 1'b1, 1'b0); chk("lit_rr3", 64'(mgr_gnt), 64'h8);
        drive(4'hF, 1'b1, 1'b0); chk("lit_full_req", 64'(sbr_req), 64'd0);
        chk("lit_full_gnt", 64'(mgr_gnt), 64'd0);
        drive(4'hF, 1'b1, 1'b1); chk("lit_rr4", 64'(mgr_gnt), 64'h1);
        chk("lit_pp_rvalid", 64'(mgr_rvalid), 64'h1);
        drive(4'hF, 1'b1, 1'b0); chk("lit_still_full", 64'(sbr_req), 64'd0);
        drive(4'h0, 1'b0, 1'b1); chk("lit_drain1", 64'(mgr_rvalid), 64'h2);
        drive(4'h0, 1'b0, 1'b1); chk("lit_drain2", 64'(mgr_rvalid), 64'h4);
        drive(4'h0, 1'b0, 1'b1); chk("lit_drain3", 64'(mgr_rvalid), 64'h8);
        drive(4'h0, 1'b0, 1'b1); chk("lit_drain4", 64'(mgr_rvalid), 64'h1);
        // Response with nothing outstanding
        drive(4'h0, 1'b0, 1'b1);
        chk("lit_stray_rv", 64'(mgr_rvalid), 64'd0);
        chk("lit_stray_fault", 64'(fault), 64'd1);
        drive(4'h0, 1'b0, 1'b0); chk("lit_stray_once", 64'(fault), 64'd0);

        // Lock: mgr 2 waits through three stalled cycles while mgr 0 joins
        drive(4'h4, 1'b0, 1'b0); chk("lit_lock_a", 64'(sbr_other), 64'h1_0000_0222);
        drive(4'h5, 1'b0, 1'b0); chk("lit_lock_b", 64'(sbr_other), 64'h1_0000_0222);
        drive(4'h5, 1'b0, 1'b0); chk("lit_lock_c", 64'(sbr_other), 64'h1_0000_0222);
        drive(4'h5, 1'b1, 1'b0); chk("lit_lock_gnt", 64'(mgr_gnt), 64'h4);
        drive(4'h1, 1'b1, 1'b0); chk("lit_lock_next", 64'(mgr_gnt), 64'h1);

        // Reset with two outstanding: entries discarded, priority back at 0
        step(); rst_ni = 1'b0; mgr_req = 4'hF; sbr_gnt = 1'b1; sbr_rvalid = 1'b0;
        drive(4'hF, 1'b1, 1'b0);
        step(); rst_ni = 1'b1; mgr_req = 4'h0; sbr_gnt = 1'b0; sbr_rvalid = 1'b1; #2;
        chk("lit_post_rst_fault", 64'(fault), 64'd1);
        chk("lit_post_rst_rv", 64'(mgr_rvalid), 64'd0);
        drive(4'hF, 1'b1, 1'b0); chk("lit_post_rst_prio", 64'(mgr_gnt), 64'h1);
        drive(4'h0, 1'b0, 1'b1); chk("lit_post_rst_route", 64'(mgr_rvalid), 64'h1);

        // Dropped request while stalled
        drive(4'h2, 1'b0, 1'b0); chk("lit_drop_pre", 64'(fault), 64'd0);
        drive(4'h8, 1'b0, 1'b0); chk("lit_drop_fault", 64'(fault), 64'd1);
        chk("lit_drop_resel", 64'(sbr_other), 64'h1_0000_0333);
        drive(4'h8, 1'b1, 1'b0); chk("lit_drop_gnt", 64'(mgr_gnt), 64'h8);
        drive(4'h0, 1'b0, 1'b1); chk("lit_drop_route", 64'(mgr_rvalid), 64'h8);

`ifdef RELOBI_A_ARB_ECC_CHECK_EN
        // One flipped check bit on the granted manager: flagged but still forwarded
        step();
        ecc_a[1] = enc(other_a[1]) ^ 7'h04;
        mgr_req = 4'h2; sbr_gnt = 1'b1; sbr_rvalid = 1'b0; #2;
        chk("lit_ecc_fault", 64'(fault), 64'd1);
        chk("lit_ecc_gnt", 64'(mgr_gnt), 64'h2);
        chk("lit_ecc_fwd", 64'(sbr_other_ecc), 64'(enc(other_a[1]) ^ 7'h04));
        step();
        ecc_a[1] = enc(other_a[1]);
        mgr_req = 4'h0; sbr_gnt = 1'b0; sbr_rvalid = 1'b1; #2;
        chk("lit_ecc_clear", 64'(fault), 64'd0);
`endif

        // Randomized traffic, checked by the reference model each cycle
        for (int c = 0; c < 3000; c++) begin
            step();
            rst_ni = ($urandom_range(0, 299) != 0);
            if ($urandom_range(0, 4) == 0) mgr_req = NM'($urandom);
            else if ($urandom_range(0, 3) == 0) mgr_req = mgr_req & NM'($urandom);
            sbr_gnt    = ($urandom_range(0, 3) != 0);
            sbr_rvalid = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 3) == 0) begin
                tmp = OW'({$urandom, $urandom});
                set_mgr(int'($urandom_range(0, NM-1)), tmp);
            end
`ifdef RELOBI_A_ARB_ECC_CHECK_EN
            if ($urandom_range(0, 15) == 0) ecc_a[0] = ecc_a[0] ^ EW'(1 << $urandom_range(0, EW-1));
            else ecc_a[0] = enc(other_a[0]);
`endif
        end
        step(); rst_ni = 1'b1;
        step();
        #2;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
